// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: issues sequential fetches with one request
// outstanding, buffers responses with their PCs and handles execute-stage redirects.
module pc_fetch_unit #(
  parameter int                   DATA_WIDTH = 32,
  parameter int                   BUS_WIDTH  = 32,
  parameter logic [BUS_WIDTH-1:0] RESET_PC   = '0,
  parameter int                   FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jump_en,
  input  logic [BUS_WIDTH-1:0]  jump_addr,
  input  logic                  hold,
  output logic                  imem_req,
  output logic [BUS_WIDTH-1:0]  imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instruction_o,
  output logic [BUS_WIDTH-1:0]  pc_o,
  output logic                  inst_valid_o
);

  localparam int PTR_W = (FIFO_DEPTH == 4) ? 2 : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t                 state;
  logic [BUS_WIDTH-1:0]   fetch_pc;
  logic [BUS_WIDTH-1:0]   req_pc;
  logic [BUS_WIDTH-1:0]   last_pc;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       count;

  logic [DATA_WIDTH-1:0]  data_mem [FIFO_DEPTH];
  logic [BUS_WIDTH-1:0]   pc_mem   [FIFO_DEPTH];

  logic                   empty;
  logic                   returning;
  logic                   push;
  logic                   pop;
  logic                   grant;
  logic [CNT_W-1:0]       occ;

  // Occupancy counts the response landing this cycle so a new request can
  // never produce a response with nowhere to go.
  always_comb begin
    empty     = (count == '0);
    returning = (state == WAIT) && imem_rvalid;
    push      = returning && !jump_en;
    pop       = !empty && !hold && !jump_en;
    occ       = count + CNT_W'(returning) - CNT_W'(pop);
    imem_req  = !jump_en && ((state == IDLE) || returning) && (occ < CNT_W'(FIFO_DEPTH));
    grant     = imem_req && imem_gnt;
  end

  assign imem_addr     = fetch_pc;
  assign inst_valid_o  = !empty;
  assign instruction_o = empty ? '0 : data_mem[rd_ptr];
  assign pc_o          = empty ? last_pc : pc_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      last_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      last_pc <= pc_o;
      if (jump_en) begin
        fetch_pc <= jump_addr;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        case (state)
          WAIT:    state <= imem_rvalid ? IDLE : DROP;
          DROP:    if (imem_rvalid) state <= IDLE;
          default: state <= IDLE;
        endcase
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + BUS_WIDTH'(4);
          req_pc   <= fetch_pc;
        end
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
        case (state)
          IDLE:    if (grant) state <= WAIT;
          WAIT:    if (imem_rvalid) state <= grant ? WAIT : IDLE;
          DROP:    if (imem_rvalid) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Storage has no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomised bench: memory model with variable latency, scoreboard of granted
// fetches, and a monitor checking consumed instructions and interface rules.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_en, hold, imem_gnt, imem_rvalid;
  logic [31:0] jump_addr, imem_rdata;
  logic        imem_req, inst_valid_o;
  logic [31:0] imem_addr, instruction_o, pc_o;

  logic        req2, valid2, rvalid2;
  logic [31:0] addr2, instr2, pc2;

  always #5 clk = ~clk;

  pc_fetch_unit #(.DATA_WIDTH(32), .BUS_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .jump_en(jump_en), .jump_addr(jump_addr), .hold(hold),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction_o(instruction_o), .pc_o(pc_o), .inst_valid_o(inst_valid_o));

  // Second instance only exercises the PC wrap from the top of the address space.
  pc_fetch_unit #(.DATA_WIDTH(32), .BUS_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .jump_en(1'b0), .jump_addr(32'h0), .hold(1'b1),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(1'b1),
    .imem_rvalid(rvalid2), .imem_rdata(32'h0),
    .instruction_o(instr2), .pc_o(pc2), .inst_valid_o(valid2));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rvalid2 <= 1'b0;
    else        rvalid2 <= req2;

  int compared = 0;
  int mismatched = 0;

  // Stimulus knobs
  int lat_min = 1, lat_max = 1, gnt_pct = 100, hold_pct = 0, jump_pct = 0, jrv_pct = 0;
  bit jump_after8 = 0;
  bit check_latency = 0;

  // Memory model state
  bit          mem_out = 0;
  int          mem_cd = 0;
  logic [31:0] mem_addr = 0;
  bit          last_granted = 0;
  logic [31:0] last_gaddr = 0;

  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } exp_t;
  exp_t exp_q[$];

  logic [31:0] d2_addr [2];
  int          d2_cnt = 0;

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle after the driver has settled the inputs.
  task automatic monitor_loop();
    logic [31:0] model_pc = 32'h0;
    bit          mon_out = 0;
    bit          prev_rst = 0, prev_jump = 0, prev_resolved = 0, prev_hold = 0, prev_valid = 0;
    logic [31:0] prev_jaddr = 0, prev_pc = 0, prev_ins = 0;
    int          cycle = 0, first_grant_cyc = -1;
    bit          first_valid_seen = 0;
    bit          granted, popped, resolved;
    exp_t        e;
    forever begin
      @(negedge clk);
      #2;
      cycle++;
      if (!rst_n) begin
        check(!inst_valid_o && instruction_o == 32'h0 && pc_o == 32'h0, "reset_outputs", pc_o, 32'h0);
        exp_q.delete();
        model_pc = 32'h0;
        mon_out = 0;
        first_grant_cyc = -1;
        first_valid_seen = 0;
        prev_rst = 0;
      end else begin
        granted  = imem_req && imem_gnt;
        popped   = inst_valid_o && !hold && !jump_en;
        resolved = !mon_out || imem_rvalid;

        if (d2_cnt < 2 && req2) begin
          d2_addr[d2_cnt] = addr2;
          d2_cnt++;
        end
        if (granted)
          check(!mon_out || imem_rvalid, "one_outstanding", imem_addr, 32'h0);
        if (prev_rst && prev_jump && prev_resolved && !jump_en)
          check(imem_req && imem_addr == prev_jaddr, "jump_restart", imem_addr, prev_jaddr);
        if (prev_rst && prev_hold && !prev_jump && prev_valid)
          check(inst_valid_o && pc_o == prev_pc && instruction_o == prev_ins, "hold_stable", pc_o, prev_pc);
        if (!inst_valid_o)
          check(instruction_o == 32'h0, "empty_instr", instruction_o, 32'h0);

        if (granted && first_grant_cyc < 0) first_grant_cyc = cycle;
        if (check_latency && inst_valid_o && !first_valid_seen) begin
          first_valid_seen = 1;
          check(cycle - first_grant_cyc == 2 && pc_o == 32'h0, "first_latency",
                32'(cycle - first_grant_cyc), 32'd2);
        end

        if (popped) begin
          check(exp_q.size() != 0, "pop_expected", pc_o, 32'h0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(pc_o == e.pc && instruction_o == e.ins, "pop_data", pc_o, e.pc);
          end
        end
        if (granted) begin
          check(imem_addr == model_pc, "fetch_addr", imem_addr, model_pc);
          exp_q.push_back({model_pc, ins_of(model_pc)});
          model_pc = model_pc + 32'd4;
        end
        if (jump_en) begin
          exp_q.delete();
          model_pc = jump_addr;
        end

        if (imem_rvalid) mon_out = 0;
        if (granted)     mon_out = 1;
        prev_rst      = 1;
        prev_jump     = jump_en;
        prev_resolved = resolved;
        prev_jaddr    = jump_addr;
        prev_hold     = hold;
        prev_valid    = inst_valid_o;
        prev_pc       = pc_o;
        prev_ins      = instruction_o;
      end
    end
  endtask

  task automatic step(output bit req_s, output bit pop_s);
    int lat;
    @(negedge clk);
    if (mem_out && mem_cd == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = ins_of(mem_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    hold = ($urandom_range(99) < hold_pct);
    if (jump_after8 && last_granted && last_gaddr == 32'h8) begin
      jump_en   = 1'b1;
      jump_addr = 32'h100;
    end else begin
      jump_en   = ($urandom_range(99) < jump_pct) || (imem_rvalid && ($urandom_range(99) < jrv_pct));
      jump_addr = $urandom & 32'hFFFF_FFFC;
    end
    #1;
    imem_gnt = ($urandom_range(99) < gnt_pct);
    req_s = imem_req;
    pop_s = inst_valid_o && !hold && !jump_en;
    last_granted = imem_req && imem_gnt;
    last_gaddr   = imem_addr;
    if (imem_rvalid) mem_out = 0;
    else if (mem_out) mem_cd--;
    if (last_granted) begin
      lat      = $urandom_range(lat_max, lat_min);
      mem_out  = 1;
      mem_addr = imem_addr;
      mem_cd   = lat - 1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    jump_en = 1'b0; jump_addr = 32'h0; hold = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    mem_out = 0; last_granted = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check(imem_req == 1'b1 && imem_addr == 32'h0, "req_after_reset", imem_addr, 32'h0);
  endtask

  initial begin
    bit r, p;
    int pops;
    fork
      monitor_loop();
    join_none

    // Back-to-back single-cycle memory: latency and throughput
    do_reset();
    check_latency = 1;
    repeat (5) step(r, p);
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      step(r, p);
      if (p) pops++;
    end
    check(pops == 20, "throughput", 32'(pops), 32'd20);
    check_latency = 0;
    check(d2_cnt == 2 && d2_addr[0] == 32'hFFFF_FFFC, "rst_pc_first", d2_addr[0], 32'hFFFF_FFFC);
    check(d2_cnt == 2 && d2_addr[1] == 32'h0, "rst_pc_wrap", d2_addr[1], 32'h0);

    // Sustained hold fills the buffer and stops fetching
    hold_pct = 100;
    for (int i = 0; i < 6; i++) step(r, p);
    check(r == 1'b0, "full_no_req", 32'(r), 32'h0);
    hold_pct = 0;
    repeat (10) step(r, p);

    // Jump while a slow fetch of 0x8 is outstanding
    do_reset();
    lat_min = 3; lat_max = 3; jump_after8 = 1;
    repeat (30) step(r, p);
    jump_after8 = 0;

    // Random traffic including jumps coincident with responses
    do_reset();
    lat_min = 1; lat_max = 3; gnt_pct = 70; hold_pct = 30; jump_pct = 5; jrv_pct = 15;
    repeat (1500) step(r, p);

    // Reset while waiting, late response after release
    do_reset();
    lat_min = 3; lat_max = 3; gnt_pct = 100; hold_pct = 0; jump_pct = 0; jrv_pct = 0;
    for (int i = 0; i < 10 && !mem_out; i++) step(r, p);
    step(r, p);
    @(negedge clk);
    rst_n = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b0; jump_en = 1'b0; hold = 1'b0;
    mem_out = 0; last_granted = 0;
    @(negedge clk);
    rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; imem_gnt = 1'b0;
    lat_min = 1; lat_max = 1;
    repeat (20) step(r, p);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
